// File: rtl/avr_io_irq.sv
// avr_io_irq: four-line interrupt controller behind a 4-register I/O window.
// Each line latches into a pending bit in either level mode or rising-edge
// mode. The enabled pending lines are priority-encoded (line 0 has the
// highest priority) into the registered iflag/ivect outputs sent to the core.
module avr_io_irq (
    input  logic       clk,
    input  logic       rst,
    input  logic       io_re,
    input  logic       io_we,
    input  logic [1:0] io_a,
    input  logic [7:0] io_wdata,
    output logic [7:0] io_rdata,
    input  logic [3:0] irq_in,
    input  logic       irq_ack,
    output logic       iflag,
    output logic [1:0] ivect
);

    localparam logic [1:0] A_IMSK  = 2'd0;
    localparam logic [1:0] A_IPND  = 2'd1;
    localparam logic [1:0] A_IEDG  = 2'd2;
    localparam logic [1:0] A_ISTAT = 2'd3;

    logic       gie;
    logic [3:0] line_en;
    logic [3:0] iedg;
    logic [3:0] pend;
    logic [3:0] irq_prev;

    logic       wr_msk, wr_pnd, wr_edg;
    logic [3:0] edge_hit, w1c, ack_clr, mode_chg, pend_nxt, active;
    logic       iflag_nxt;
    logic [1:0] ivect_nxt;

    // Pending-bit next state, plus the priority encoder for the core request
    always_comb begin
        wr_msk   = io_we && (io_a == A_IMSK);
        wr_pnd   = io_we && (io_a == A_IPND);
        wr_edg   = io_we && (io_a == A_IEDG);
        edge_hit = irq_in & ~irq_prev;
        w1c      = wr_pnd ? io_wdata[3:0] : 4'b0000;
        // An ack only counts while a request is actually being presented
        ack_clr  = (irq_ack && iflag) ? (4'b0001 << ivect) : 4'b0000;
        mode_chg = wr_edg ? (io_wdata[3:0] ^ iedg) : 4'b0000;
        pend_nxt = 4'b0000;
        for (int i = 0; i < 4; i++) begin
            if (mode_chg[i])
                pend_nxt[i] = 1'b0;
            else if (iedg[i])
                // A new edge beats a concurrent W1C or ack on the same bit
                pend_nxt[i] = edge_hit[i] | (pend[i] & ~(w1c[i] | ack_clr[i]));
            else
                pend_nxt[i] = irq_in[i];
        end
        active    = pend & line_en & {4{gie}};
        iflag_nxt = |active;
        ivect_nxt = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (active[i]) ivect_nxt = 2'(i);
        end
    end

    // Register file, edge history, pending bits and the outputs to the core
    always_ff @(posedge clk) begin
        if (rst) begin
            gie      <= 1'b0;
            line_en  <= 4'b0000;
            iedg     <= 4'b0000;
            pend     <= 4'b0000;
            irq_prev <= 4'b0000;
            iflag    <= 1'b0;
            ivect    <= 2'd0;
        end else begin
            if (wr_msk) begin
                gie     <= io_wdata[7];
                line_en <= io_wdata[3:0];
            end
            if (wr_edg) iedg <= io_wdata[3:0];
            pend     <= pend_nxt;
            irq_prev <= irq_in;
            iflag    <= iflag_nxt;
            ivect    <= ivect_nxt;
        end
    end

    // Read mux; returns zero when not selected so the top can OR the buses together
    always_comb begin
        io_rdata = 8'h00;
        if (io_re) begin
            case (io_a)
                A_IMSK:  io_rdata = {gie, 3'b000, line_en};
                A_IPND:  io_rdata = {4'b0000, pend};
                A_IEDG:  io_rdata = {4'b0000, iedg};
                A_ISTAT: io_rdata = {iflag, 5'b00000, ivect};
                default: io_rdata = 8'h00;
            endcase
        end
    end

endmodule
